// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    START,
    WAIT_DONE
  } arb_state_t;

  // Modular add for small requester indices; b never exceeds n, so one subtract suffices.
  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first valid requester at or after rr_ptr, with wrap-around.
module rr_pick
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] winner,
  output logic             found
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = IDX_W'(wrap_add(int'(rr_ptr), i, N_REQ));
      if (!found && req_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one async_transmitter between N_REQ byte streams with bursts.
// Define UART_ARB_PRIO_EN to give requester 0 strict priority over the rotation.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 8,
  localparam int IDX_W    = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         tx_start,
  output logic [UART_BYTE_W-1:0]       tx_data,
  input  logic                         tx_busy,
  output logic [IDX_W-1:0]             grant_id,
  output logic                         active
);

  localparam logic [7:0] MAX_BURST_B = 8'(MAX_BURST);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_id_q, grant_id_d;
  logic [7:0]             burst_cnt_q, burst_cnt_d;
  logic                   last_q, last_d;
  logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;
  logic                   tx_start_q, tx_start_d;
  logic [N_REQ-1:0]       req_ready_q, req_ready_d;
  logic                   active_q, active_d;

  logic [UART_BYTE_W-1:0] req_bytes [N_REQ];
  logic [IDX_W-1:0]       rr_winner, pick_idx;
  logic                   rr_found, pick_found;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_bytes[i] = req_data[i*UART_BYTE_W +: UART_BYTE_W];
    end
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .winner    (rr_winner),
    .found     (rr_found)
  );

`ifdef UART_ARB_PRIO_EN
  // Requester 0 overrides the rotation; the others still rotate via rr_ptr.
  assign pick_found = rr_found | req_valid[0];
  assign pick_idx   = req_valid[0] ? '0 : rr_winner;
`else
  assign pick_found = rr_found;
  assign pick_idx   = rr_winner;
`endif

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    last_d      = last_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = tx_start_q;
    req_ready_d = '0;

    case (state_q)
      IDLE: begin
        // A frame left over from before a reset must finish before a new grant.
        if (pick_found && !tx_busy) begin
          grant_id_d            = pick_idx;
          burst_cnt_d           = '0;
          req_ready_d[pick_idx] = 1'b1;
          state_d               = GRANT;
        end
      end
      GRANT: begin
        tx_data_d   = req_bytes[grant_id_q];
        last_d      = req_last[grant_id_q];
        burst_cnt_d = (burst_cnt_q == 8'hFF) ? burst_cnt_q : burst_cnt_q + 8'd1;
        tx_start_d  = 1'b1;
        state_d     = START;
      end
      START: begin
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (!last_q && (burst_cnt_q < MAX_BURST_B) && req_valid[grant_id_q]) begin
            req_ready_d[grant_id_q] = 1'b1;
            state_d                 = GRANT;
          end else begin
            rr_ptr_d = IDX_W'(wrap_add(int'(grant_id_q), 1, N_REQ));
            state_d  = IDLE;
          end
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = IDLE;
      end
    endcase

    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      last_q      <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      req_ready_q <= req_ready_d;
      active_q    <= active_d;
    end
  end

  assign req_ready = req_ready_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_id_q;
  assign active    = active_q;

endmodule
